// File: rtl/edm_sram_reader_pkg.sv
// Shared types and constants for the EDM SRAM read engine.
//   - SRAM window bounds, engine defaults
//   - OBI request/response payload structs (croc default configuration)
//   - read-engine FSM state encoding
package edm_sram_reader_pkg;

  localparam logic [31:0] CrocSramAddrOffset = 32'h1000_0000;
  localparam logic [31:0] CrocSramAddrRange  = 32'h0000_4000;

  // Window end is exclusive and kept 33 bits wide so base+len never wraps
  localparam logic [31:0] EdmRdWindowStart = CrocSramAddrOffset;
  localparam logic [32:0] EdmRdWindowEnd   = 33'(CrocSramAddrOffset) + 33'(CrocSramAddrRange);

  localparam int unsigned EdmRdMaxOutstanding = 2;
  localparam int unsigned EdmRdFifoDepth      = 4;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic                    err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } edm_rd_state_e;

endpackage

// File: rtl/edm_sram_reader_fifo.sv
// Response buffer for the EDM read engine (fifo_v3 style, no fall-through).
// Ports: clk_i/rst_ni, push_i+data_i write side, pop_i read side,
//        data_o head word, empty_o, usage_o fill level.
module edm_sram_reader_fifo #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [DataWidth-1:0]           data_i,
  input  logic                           pop_i,
  output logic [DataWidth-1:0]           data_o,
  output logic                           empty_o,
  output logic [$clog2(Depth+1)-1:0]     usage_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      rd_q, wr_q;
  logic [CntW-1:0]      cnt_q;
  logic                 full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (32'(cnt_q) == Depth);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];
  assign usage_o = cnt_q;

  // Pointers and fill level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Storage needs no reset; contents are only observed when count > 0
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/edm_sram_reader.sv
// OBI manager read engine feeding the EDM datapath from SRAM0.
// Ports: clk_i/rst_ni; start_i, base_addr_i, num_words_i job request;
//        busy_o, done_o, err_o job status; obi_req_o/obi_rsp_i OBI manager port;
//        data_o/valid_o/ready_i output word stream.
module edm_sram_reader #(
  parameter type         obi_req_t      = edm_sram_reader_pkg::obi_req_t,
  parameter type         obi_rsp_t      = edm_sram_reader_pkg::obi_rsp_t,
  parameter int unsigned MaxOutstanding = edm_sram_reader_pkg::EdmRdMaxOutstanding,
  parameter int unsigned FifoDepth      = edm_sram_reader_pkg::EdmRdFifoDepth
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] num_words_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i
);

  import edm_sram_reader_pkg::*;

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  edm_rd_state_e   state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [15:0]     num_q, num_d;
  logic [15:0]     issued_q, issued_d;
  logic [OutW-1:0] outst_q, outst_d;
  logic            err_q, err_d;
  logic            hold_q, hold_d;

  logic            range_fail;
  logic [32:0]     range_end;
  logic            can_issue, req_c, req_fire, rsp_err, push;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_usage;

  // Window check on the raw start inputs
  always_comb begin
    range_end  = 33'(base_addr_i) + 33'({num_words_i, 2'b00});
    range_fail = (base_addr_i[1:0] != 2'b00) || (num_words_i == '0) ||
                 (base_addr_i < EdmRdWindowStart) || (range_end > EdmRdWindowEnd);
  end

  // Credit: never hold more words in flight + buffered than the FIFO can take.
  // A request that was raised but not yet granted is held regardless of state.
  always_comb begin
    can_issue = (state_q == RUN) && !err_q && (issued_q < num_q) &&
                (outst_q < OutW'(MaxOutstanding)) &&
                ((32'(outst_q) + 32'(fifo_usage)) < FifoDepth);
    req_c     = can_issue || hold_q;
    req_fire  = req_c && obi_rsp_i.gnt;
    rsp_err   = obi_rsp_i.rvalid && obi_rsp_i.r.err;
    push      = obi_rsp_i.rvalid && !obi_rsp_i.r.err && !err_q;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    num_d    = num_q;
    issued_d = issued_q;
    err_d    = err_q;
    hold_d   = req_c && !obi_rsp_i.gnt;
    outst_d  = outst_q + OutW'(req_fire) - OutW'(obi_rsp_i.rvalid);

    if (req_fire) begin
      addr_d   = addr_q + 32'd4;
      issued_d = issued_q + 16'd1;
    end
    if (rsp_err) err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (range_fail) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            addr_d   = base_addr_i;
            num_d    = num_words_i;
            issued_d = '0;
            err_d    = 1'b0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (rsp_err || (issued_d == num_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((outst_q == '0) && fifo_empty && !hold_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
    end
  end

  // Read-only request; address comes straight from the register so it is
  // stable for as long as req waits for gnt
  always_comb begin
    obi_req_o         = '0;
    obi_req_o.req     = req_c;
    obi_req_o.a.addr  = addr_q;
    obi_req_o.a.we    = 1'b0;
    obi_req_o.a.be    = 4'hF;
    obi_req_o.a.wdata = '0;
  end

  assign busy_o  = (state_q == RUN) || (state_q == DRAIN);
  assign done_o  = (state_q == DONE);
  assign err_o   = err_q;
  assign valid_o = !fifo_empty;

  edm_sram_reader_fifo #(
    .DataWidth (32),
    .Depth     (FifoDepth)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (obi_rsp_i.r.rdata),
    .pop_i   (valid_o && ready_i),
    .data_o  (data_o),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

endmodule

// File: tb/tb_edm_sram_reader.sv
// Directed bench for edm_sram_reader with a small OBI SRAM model.
module tb_edm_sram_reader;

  import edm_sram_reader_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_words;
  logic        busy, done, err;
  obi_req_t    obi_req;
  obi_rsp_t    obi_rsp;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  int checks = 0;
  int errors = 0;

  edm_sram_reader #(
    .MaxOutstanding (2),
    .FifoDepth      (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start),
    .base_addr_i (base_addr),
    .num_words_i (num_words),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .obi_req_o   (obi_req),
    .obi_rsp_i   (obi_rsp),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // ---------------- SRAM model: gnt after gnt_delay waiting cycles, rvalid 1 cycle later
  int          gnt_delay = 0;
  int          err_at    = -1;
  int          wait_cnt;
  int          grant_idx;
  logic        gnt;
  logic        rv_q, rerr_q;
  logic [31:0] rdata_q;

  assign gnt = obi_req.req && (wait_cnt >= gnt_delay);

  always_comb begin
    obi_rsp         = '0;
    obi_rsp.gnt     = gnt;
    obi_rsp.rvalid  = rv_q;
    obi_rsp.r.rdata = rdata_q;
    obi_rsp.r.err   = rerr_q;
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rv_q      <= 1'b0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
      wait_cnt  <= 0;
      grant_idx <= 0;
    end else begin
      rv_q    <= obi_req.req && gnt;
      rdata_q <= pat(obi_req.a.addr);
      rerr_q  <= obi_req.req && gnt && (grant_idx == err_at);
      if (start && !busy)           grant_idx <= 0;
      else if (obi_req.req && gnt)  grant_idx <= grant_idx + 1;
      if (obi_req.req && gnt)       wait_cnt <= 0;
      else if (obi_req.req)         wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- Monitor (samples on the falling edge)
  int          cyc = 0;
  int          fire_cnt = 0, rv_cnt = 0, done_cnt = 0;
  int          stab_viol = 0, bad_attr = 0, fires_after_err = 0;
  int          outst = 0, max_outst = 0;
  int          last_pop_cyc = 0, done_cyc = 0;
  bit          err_seen = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] rx_q[$];
  logic [31:0] ga_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_ni) begin
      outst = 0;
      pend  = 1'b0;
    end else begin
      if (start && !busy) err_seen = 1'b0;
      if (pend && (!obi_req.req || obi_req.a.addr != pend_addr)) stab_viol++;
      if (obi_req.req && (obi_req.a.we || obi_req.a.be != 4'hF)) bad_attr++;
      if (obi_req.req && gnt) begin
        fire_cnt++;
        outst++;
        ga_q.push_back(obi_req.a.addr);
        if (err_seen) fires_after_err++;
      end
      if (obi_rsp.rvalid) begin
        rv_cnt++;
        outst--;
        if (obi_rsp.r.err) err_seen = 1'b1;
      end
      if (outst > max_outst) max_outst = outst;
      pend      = obi_req.req && !gnt;
      pend_addr = obi_req.a.addr;
      if (valid && ready) begin
        rx_q.push_back(data);
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- Stimulus helpers
  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    int d0;
    d0 = done_cnt;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        to = 1'b0;
        break;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- Tests
  task automatic test_reset();
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (obi_req.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", obi_req.req); end
  endtask

  task automatic test_range_err();
    logic [31:0] bases [4] = '{32'h1000_0002, 32'h1000_3FFC, 32'h1000_0000, 32'h0FFF_FFF0};
    logic [15:0] nums  [4] = '{16'd1, 16'd2, 16'd0, 16'd2};
    int f0;
    for (int k = 0; k < 4; k++) begin
      f0 = fire_cnt;
      do_start(bases[k], nums[k]);
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL range%0d_done_pulse got %b want 1", k, done); end
      checks++; if (err !== 1'b1)  begin errors++; $display("FAIL range%0d_err got %b want 1", k, err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL range%0d_busy got %b want 0", k, busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL range%0d_done_width got %b want 0", k, done); end
      checks++; if (fire_cnt - f0 != 0) begin errors++; $display("FAIL range%0d_no_req got %0d reads want 0", k, fire_cnt - f0); end
      checks++; if (obi_req.req !== 1'b0) begin errors++; $display("FAIL range%0d_req_idle got %b want 0", k, obi_req.req); end
    end
  endtask

  task automatic test_basic();
    int r0, g0, ba0;
    bit to;
    logic [31:0] b;
    b = 32'h1000_0000;
    ready = 1'b1; gnt_delay = 0; err_at = -1;
    r0 = rx_q.size(); g0 = ga_q.size(); ba0 = bad_attr;
    do_start(b, 16'd8);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL basic_err_cleared got %b want 0", err); end
    wait_done(200, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout no done within 200 cycles"); end
    checks++; if (rx_q.size() - r0 != 8) begin errors++; $display("FAIL basic_count got %0d want 8", rx_q.size() - r0); end
    checks++; if (ga_q.size() - g0 != 8) begin errors++; $display("FAIL basic_reads got %0d want 8", ga_q.size() - g0); end
    for (int i = 0; i < 8; i++) begin
      if (r0 + i < rx_q.size()) begin
        checks++; if (rx_q[r0+i] !== pat(b + 32'(4*i))) begin errors++; $display("FAIL basic_data%0d got %h want %h", i, rx_q[r0+i], pat(b + 32'(4*i))); end
      end
      if (g0 + i < ga_q.size()) begin
        checks++; if (ga_q[g0+i] !== b + 32'(4*i)) begin errors++; $display("FAIL basic_addr%0d got %h want %h", i, ga_q[g0+i], b + 32'(4*i)); end
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err_end got %b want 0", err); end
    checks++; if (!(done_cyc > last_pop_cyc)) begin errors++; $display("FAIL basic_done_after_pop done cyc %0d last pop cyc %0d", done_cyc, last_pop_cyc); end
    checks++; if (bad_attr != ba0) begin errors++; $display("FAIL basic_attr got %0d bad requests want 0", bad_attr - ba0); end
  endtask

  task automatic test_backpressure();
    int r0, f0, v0;
    bit to;
    logic [31:0] b;
    b = 32'h1000_0040;
    ready = 1'b0; gnt_delay = 0; err_at = -1;
    r0 = rx_q.size(); f0 = fire_cnt; v0 = rv_cnt;
    do_start(b, 16'd8);
    repeat (20) @(negedge clk);
    checks++; if (fire_cnt - f0 != 4) begin errors++; $display("FAIL bp_reads_stalled got %0d want 4", fire_cnt - f0); end
    checks++; if (rv_cnt - v0 != 4)   begin errors++; $display("FAIL bp_buffered got %0d want 4", rv_cnt - v0); end
    checks++; if (valid !== 1'b1)     begin errors++; $display("FAIL bp_valid got %b want 1", valid); end
    checks++; if (data !== pat(b))    begin errors++; $display("FAIL bp_head got %h want %h", data, pat(b)); end
    @(posedge clk); #1 ready = 1'b1;
    wait_done(200, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout no done within 200 cycles"); end
    checks++; if (rx_q.size() - r0 != 8) begin errors++; $display("FAIL bp_count got %0d want 8", rx_q.size() - r0); end
    for (int i = 0; i < 8; i++) begin
      if (r0 + i < rx_q.size()) begin
        checks++; if (rx_q[r0+i] !== pat(b + 32'(4*i))) begin errors++; $display("FAIL bp_data%0d got %h want %h", i, rx_q[r0+i], pat(b + 32'(4*i))); end
      end
    end
  endtask

  task automatic test_gnt_delay();
    int r0, s0;
    bit to;
    logic [31:0] b;
    b = 32'h1000_0200;
    ready = 1'b1; gnt_delay = 3; err_at = -1;
    r0 = rx_q.size(); s0 = stab_viol;
    do_start(b, 16'd8);
    wait_done(400, to);
    checks++; if (to) begin errors++; $display("FAIL gd_timeout no done within 400 cycles"); end
    checks++; if (stab_viol != s0) begin errors++; $display("FAIL gd_req_stable got %0d violations want 0", stab_viol - s0); end
    checks++; if (max_outst > 2)   begin errors++; $display("FAIL gd_outstanding got %0d want <=2", max_outst); end
    checks++; if (rx_q.size() - r0 != 8) begin errors++; $display("FAIL gd_count got %0d want 8", rx_q.size() - r0); end
    for (int i = 0; i < 8; i++) begin
      if (r0 + i < rx_q.size()) begin
        checks++; if (rx_q[r0+i] !== pat(b + 32'(4*i))) begin errors++; $display("FAIL gd_data%0d got %h want %h", i, rx_q[r0+i], pat(b + 32'(4*i))); end
      end
    end
    gnt_delay = 0;
  endtask

  task automatic test_resp_err();
    int r0, a0;
    bit to;
    logic [31:0] b;
    b = 32'h1000_0100;
    ready = 1'b1; gnt_delay = 0; err_at = 2;
    r0 = rx_q.size(); a0 = fires_after_err;
    do_start(b, 16'd6);
    wait_done(200, to);
    checks++; if (to) begin errors++; $display("FAIL rerr_timeout no done within 200 cycles"); end
    checks++; if (rx_q.size() - r0 != 2) begin errors++; $display("FAIL rerr_count got %0d want 2", rx_q.size() - r0); end
    for (int i = 0; i < 2; i++) begin
      if (r0 + i < rx_q.size()) begin
        checks++; if (rx_q[r0+i] !== pat(b + 32'(4*i))) begin errors++; $display("FAIL rerr_data%0d got %h want %h", i, rx_q[r0+i], pat(b + 32'(4*i))); end
      end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rerr_err got %b want 1", err); end
    checks++; if (fires_after_err != a0) begin errors++; $display("FAIL rerr_no_more_reads got %0d want 0", fires_after_err - a0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rerr_busy got %b want 0", busy); end
    err_at = -1;
  endtask

  task automatic test_reset_mid_job();
    int r0;
    bit to;
    logic [31:0] b;
    ready = 1'b0;
    do_start(32'h1000_0300, 16'd8);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_ni = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0)       begin errors++; $display("FAIL mid_rst_valid got %b want 0", valid); end
    checks++; if (obi_req.req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", obi_req.req); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL mid_rst_done got %b want 0", done); end
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL mid_rst_err got %b want 0", err); end
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    b = 32'h1000_0400;
    ready = 1'b1;
    r0 = rx_q.size();
    do_start(b, 16'd4);
    wait_done(200, to);
    checks++; if (to) begin errors++; $display("FAIL post_rst_timeout no done within 200 cycles"); end
    checks++; if (rx_q.size() - r0 != 4) begin errors++; $display("FAIL post_rst_count got %0d want 4", rx_q.size() - r0); end
    for (int i = 0; i < 4; i++) begin
      if (r0 + i < rx_q.size()) begin
        checks++; if (rx_q[r0+i] !== pat(b + 32'(4*i))) begin errors++; $display("FAIL post_rst_data%0d got %h want %h", i, rx_q[r0+i], pat(b + 32'(4*i))); end
      end
    end
  endtask

  initial begin
    rst_ni    = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #1 rst_ni = 1'b1;
    test_range_err();
    test_basic();
    test_backpressure();
    test_gnt_delay();
    test_resp_err();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
